idma_evt_tracker: RTL
=====================

IDMA_EVT_TRACKER -- requirements
Module: idma_evt_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 4, giving the width of each per-direction outstanding-transfer counter (max 2^CNT_W-1).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset is synchronous and active-low, sampled on clk_i only.
REQ-004 SHALL have port clear_i, input, 1, synchronous soft clear with the same effect as reset.
REQ-005 SHALL have ports axi2obi_start_i, axi2obi_done_i, axi2obi_error_i, input, 1 each: L2->L1 channel pulses from the iDMA controller.
REQ-006 SHALL have ports obi2axi_start_i, obi2axi_done_i, obi2axi_error_i, input, 1 each: L1->L2 channel pulses.
REQ-007 SHALL have port wait_req_i, input, 1, core request to block until the selected channels drain.
REQ-008 SHALL have port wait_dir_i, input, 2, channel select: bit0 AXI2OBI, bit1 OBI2AXI.
REQ-009 SHALL have port wait_ack_o, output, 1, one-cycle pulse: the wait completed.
REQ-010 SHALL have port wait_err_o, output, 1, valid with wait_ack_o: a sticky error is set on a selected channel.
REQ-011 SHALL have ports axi2obi_cnt_o and obi2axi_cnt_o, output, CNT_W, outstanding-transfer counts.
REQ-012 SHALL have ports axi2obi_evt_o and obi2axi_evt_o, output, 1, one-cycle drain-event pulses.
REQ-013 SHALL have port err_sticky_o, output, 2, per-channel sticky error (bit0 AXI2OBI, bit1 OBI2AXI).
REQ-014 SHALL have port ovf_sticky_o, output, 2, per-channel sticky overflow or underflow flag.
REQ-015 SHALL have port err_clr_i, input, 2, per-channel write-one-to-clear for err_sticky_o and ovf_sticky_o.

Function
REQ-016 Per channel, a completion in a cycle SHALL be defined as done_i OR error_i; done and error together SHALL count as one completion.
REQ-017 Per channel, the counter SHALL increment by 1 on start without completion, decrement by 1 on completion without start, and hold when both or neither occur.
REQ-018 A start with the counter at 2^CNT_W-1 and no completion SHALL leave the counter saturated and set that channel's ovf_sticky bit.
REQ-019 A completion with the counter at 0 and no start SHALL leave the counter at 0 and set that channel's ovf_sticky bit.
REQ-020 evt_o SHALL pulse high for exactly one cycle in the cycle after the counter register moves from 1 to 0.
REQ-021 An error_i pulse SHALL set that channel's err_sticky bit in the next cycle.
REQ-022 err_clr_i bit k SHALL clear err_sticky[k] and ovf_sticky[k] in the next cycle; a set event in the same cycle SHALL take priority over the clear.
REQ-023 The wait FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-024 The wait FSM SHALL go from IDLE to WAIT on wait_req_i and capture wait_dir_i into an internal register.
REQ-025 The wait FSM SHALL go from WAIT to ACK when every channel selected by the captured wait_dir has a counter register of 0.
REQ-026 The wait FSM SHALL go from ACK to IDLE unconditionally.
REQ-027 wait_ack_o SHALL be high only in ACK.
REQ-028 wait_err_o SHALL be high in ACK when the OR of err_sticky over the captured selected channels is 1.
REQ-029 With the selected channels already drained, wait_ack_o SHALL assert 2 cycles after wait_req_i is sampled.
REQ-030 A captured wait_dir of 2'b00 SHALL be treated as drained, so the FSM acks after 2 cycles.
REQ-031 wait_req_i SHALL be ignored in WAIT and ACK, and wait_dir_i SHALL be sampled only in IDLE.
REQ-032 Starts arriving while in WAIT SHALL extend the wait until their completions drain the counters.
REQ-033 The two channels SHALL be fully independent; simultaneous events on both channels SHALL each be applied.

Reset
REQ-034 On rst_ni=0 or clear_i=1 at a clock edge, both counters SHALL go to 0.
REQ-035 On rst_ni=0 or clear_i=1 at a clock edge, all sticky flags SHALL go to 0.
REQ-036 On rst_ni=0 or clear_i=1 at a clock edge, the FSM SHALL go to IDLE and the captured wait_dir to 0.
REQ-037 On rst_ni=0 or clear_i=1 at a clock edge, all outputs SHALL be 0 in the following cycle, and a pending wait SHALL be abandoned without ack.
REQ-038 rst_ni SHALL have priority over clear_i, and clear_i SHALL have priority over all functional updates.

Verification
REQ-039 Scenario: 3 axi2obi_start pulses, then 3 done pulses -> axi2obi_cnt_o reads 1,2,3,2,1,0; one axi2obi_evt_o pulse the cycle after reaching 0.
REQ-040 Scenario: obi2axi_start_i and obi2axi_done_i together with count 2 -> count stays 2; done with count 0 -> count stays 0 and ovf_sticky_o=2'b10.
REQ-041 Scenario: 16 axi2obi starts with CNT_W=4 -> count saturates at 15 and ovf_sticky_o[0]=1; err_clr_i=2'b01 -> flag 0 next cycle.
REQ-042 Scenario: wait_req_i with wait_dir_i=2'b11, both counts 0 -> wait_ack_o high exactly 2 cycles later for 1 cycle, wait_err_o=0.
REQ-043 Scenario: wait_dir_i=2'b01 with axi2obi count 2, then one done and one error -> ack 2 cycles after the last completion with wait_err_o=1, and err_sticky_o[0]=1.
REQ-044 Scenario: clear_i asserted while in WAIT with counts 3/1 -> next cycle counts 0, no wait_ack_o ever, FSM accepts a new wait_req_i.

Source files
------------

// File: rtl/idma_evt_tracker.sv
// idma_evt_tracker: per-direction outstanding-transfer tracking for an iDMA
// engine with drain-event pulses, sticky error/overflow flags and a
// wait-until-drained handshake for the core.
module idma_evt_tracker #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             axi2obi_start_i,
    input  logic             axi2obi_done_i,
    input  logic             axi2obi_error_i,
    input  logic             obi2axi_start_i,
    input  logic             obi2axi_done_i,
    input  logic             obi2axi_error_i,
    input  logic             wait_req_i,
    input  logic [1:0]       wait_dir_i,
    output logic             wait_ack_o,
    output logic             wait_err_o,
    output logic [CNT_W-1:0] axi2obi_cnt_o,
    output logic [CNT_W-1:0] obi2axi_cnt_o,
    output logic             axi2obi_evt_o,
    output logic             obi2axi_evt_o,
    output logic [1:0]       err_sticky_o,
    output logic [1:0]       ovf_sticky_o,
    input  logic [1:0]       err_clr_i
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Channel index 0 is AXI2OBI (L2->L1), index 1 is OBI2AXI (L1->L2).
    logic [1:0]            w_start;
    logic [1:0]            w_done;
    logic [1:0]            w_error;
    logic [1:0][CNT_W-1:0] w_cnt;
    logic [1:0]            w_evt;
    logic [1:0]            w_err_sticky;
    logic [1:0]            w_ovf_sticky;
    logic                  w_drained;

    logic [1:0]            r_state;
    logic [1:0]            r_dir;

    assign w_start = {obi2axi_start_i, axi2obi_start_i};
    assign w_done  = {obi2axi_done_i,  axi2obi_done_i};
    assign w_error = {obi2axi_error_i, axi2obi_error_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_evt;
            logic             r_err;
            logic             r_ovf;
            logic             w_cmpl;
            logic             w_inc;
            logic             w_dec;
            logic             w_ovf_set;

            // done and error in the same cycle are one completion
            assign w_cmpl    = w_done[gi] | w_error[gi];
            assign w_inc     = w_start[gi] & ~w_cmpl;
            assign w_dec     = w_cmpl & ~w_start[gi];
            assign w_ovf_set = (w_inc & (r_cnt == CNT_MAX)) |
                               (w_dec & (r_cnt == CNT_ZERO));

            // Counter, drain event and sticky flags; a set beats a same-cycle clear
            always_ff @(posedge clk_i) begin
                if (!rst_ni || clear_i) begin
                    r_cnt <= CNT_ZERO;
                    r_evt <= 1'b0;
                    r_err <= 1'b0;
                    r_ovf <= 1'b0;
                end else begin
                    if (w_inc && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else if (w_dec && (r_cnt != CNT_ZERO)) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                    r_evt <= w_dec && (r_cnt == CNT_ONE);
                    r_err <= w_error[gi] | (r_err & ~err_clr_i[gi]);
                    r_ovf <= w_ovf_set   | (r_ovf & ~err_clr_i[gi]);
                end
            end

            assign w_cnt[gi]        = r_cnt;
            assign w_evt[gi]        = r_evt;
            assign w_err_sticky[gi] = r_err;
            assign w_ovf_sticky[gi] = r_ovf;
        end
    endgenerate

    // An unselected channel never holds the wait; dir 2'b00 drains immediately.
    assign w_drained = (~r_dir[0] | (w_cnt[0] == CNT_ZERO)) &
                       (~r_dir[1] | (w_cnt[1] == CNT_ZERO));

    // Wait handshake FSM: capture direction in IDLE, hold until drained, ack once
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= ST_IDLE;
            r_dir   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wait_req_i) begin
                        r_state <= ST_WAIT;
                        r_dir   <= wait_dir_i;
                    end
                end
                ST_WAIT: begin
                    if (w_drained) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wait_ack_o    = (r_state == ST_ACK);
    assign wait_err_o    = (r_state == ST_ACK) & |(r_dir & w_err_sticky);
    assign axi2obi_cnt_o = w_cnt[0];
    assign obi2axi_cnt_o = w_cnt[1];
    assign axi2obi_evt_o = w_evt[0];
    assign obi2axi_evt_o = w_evt[1];
    assign err_sticky_o  = w_err_sticky;
    assign ovf_sticky_o  = w_ovf_sticky;

endmodule
